// File: rtl/rs_syndrome_sched_if.sv
// Bundle between the two codeword requesters, the shared syndrome unit,
// the downstream result consumer and the optional error counters.
interface rs_syndrome_sched_if #(
   parameter int N            = 18,
   parameter int SYMBOL_WIDTH = 8,
   parameter int CNT_WIDTH    = 16
);
   logic                           req0_valid;
   logic                           req0_ready;
   logic [N*SYMBOL_WIDTH-1:0]      req0_data;
   logic                           req1_valid;
   logic                           req1_ready;
   logic [N*SYMBOL_WIDTH-1:0]      req1_data;
   logic [N*SYMBOL_WIDTH-1:0]      syn_v;
   logic [SYMBOL_WIDTH-1:0]        syn_s1;
   logic [SYMBOL_WIDTH-1:0]        syn_s2;
   logic                           out_valid;
   logic                           out_ready;
   logic                           out_id;
   logic [SYMBOL_WIDTH-1:0]        out_s1;
   logic [SYMBOL_WIDTH-1:0]        out_s2;
   logic                           out_err;
   logic                           cnt_clr;
   logic [CNT_WIDTH-1:0]           err_cnt0;
   logic [CNT_WIDTH-1:0]           err_cnt1;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      input  syn_s1, syn_s2, out_ready, cnt_clr,
      output req0_ready, req1_ready, syn_v,
      output out_valid, out_id, out_s1, out_s2, out_err, err_cnt0, err_cnt1
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      output syn_s1, syn_s2, out_ready, cnt_clr,
      input  req0_ready, req1_ready, syn_v,
      input  out_valid, out_id, out_s1, out_s2, out_err, err_cnt0, err_cnt1
   );
endinterface

// File: rtl/rs_syndrome_sched.sv
// Two-requester arbiter onto a shared combinational RS(18,16) syndrome unit with a
// one-deep registered result stage. Define RS_SYND_STATS_EN for per-requester error counters.
module rs_syndrome_sched #(
   parameter int N            = 18,
   parameter int SYMBOL_WIDTH = 8,
   parameter int CNT_WIDTH    = 16
) (
   input logic                clk,
   input logic                rst,
   rs_syndrome_sched_if.slave bus
);
   localparam int CW = N * SYMBOL_WIDTH;

   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

   state_t                  r_state;
   logic                    r_ptr;
   logic                    r_out_id;
   logic                    r_out_err;
   logic [SYMBOL_WIDTH-1:0] r_out_s1;
   logic [SYMBOL_WIDTH-1:0] r_out_s2;

   logic [1:0]              w_req_valid;
   logic [1:0][CW-1:0]      w_req_data;
   logic                    w_can_accept;
   logic                    w_gnt;
   logic                    w_accept;
   logic                    w_syn_err;

   assign w_req_valid = {bus.req1_valid, bus.req0_valid};
   assign w_req_data  = {bus.req1_data, bus.req0_data};

   // out_ready feeds reqX_ready combinationally so a draining result never costs a bubble
   assign w_can_accept = ~rst & ((r_state == ST_EMPTY) | bus.out_ready);

   always_comb begin
      w_gnt = r_ptr;
      if (w_req_valid == 2'b01)      w_gnt = 1'b0;
      else if (w_req_valid == 2'b10) w_gnt = 1'b1;
   end

   assign w_accept       = w_can_accept & w_req_valid[w_gnt];
   assign w_syn_err      = |(bus.syn_s1 | bus.syn_s2);
   assign bus.syn_v      = w_req_data[w_gnt];
   assign bus.req0_ready = w_can_accept & ~w_gnt;
   assign bus.req1_ready = w_can_accept & w_gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_EMPTY;
         r_ptr     <= 1'b0;
         r_out_id  <= 1'b0;
         r_out_s1  <= '0;
         r_out_s2  <= '0;
         r_out_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_out_s1  <= bus.syn_s1;
            r_out_s2  <= bus.syn_s2;
            r_out_id  <= w_gnt;
            r_out_err <= w_syn_err;
            r_ptr     <= ~w_gnt;
         end
         case (r_state)
            ST_EMPTY: if (w_accept) r_state <= ST_FULL;
            ST_FULL:  if (!w_accept && bus.out_ready) r_state <= ST_EMPTY;
            default:  r_state <= ST_EMPTY;
         endcase
      end
   end

   assign bus.out_valid = (r_state == ST_FULL);
   assign bus.out_id    = r_out_id;
   assign bus.out_s1    = r_out_s1;
   assign bus.out_s2    = r_out_s2;
   assign bus.out_err   = r_out_err;

`ifdef RS_SYND_STATS_EN
   logic [CNT_WIDTH-1:0] r_err_cnt0;
   logic [CNT_WIDTH-1:0] r_err_cnt1;

   // clear wins over a same-cycle increment; counters stick at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cnt0 <= '0;
         r_err_cnt1 <= '0;
      end else if (bus.cnt_clr) begin
         r_err_cnt0 <= '0;
         r_err_cnt1 <= '0;
      end else if (w_accept && w_syn_err) begin
         if (!w_gnt && (r_err_cnt0 != '1)) r_err_cnt0 <= r_err_cnt0 + 1'b1;
         if (w_gnt && (r_err_cnt1 != '1))  r_err_cnt1 <= r_err_cnt1 + 1'b1;
      end
   end

   assign bus.err_cnt0 = r_err_cnt0;
   assign bus.err_cnt1 = r_err_cnt1;
`else
   logic w_unused_cnt_clr;
   assign w_unused_cnt_clr = bus.cnt_clr;
   assign bus.err_cnt0     = {CNT_WIDTH{1'b0}};
   assign bus.err_cnt1     = {CNT_WIDTH{1'b0}};
`endif
endmodule
